// File: rtl/uart_mem_bridge.sv
// Bridges a simple valid/ready CPU memory port onto a byte-stream UART link.
// Each request sends header, address and optional data bytes, then waits for read data or an ack.
module uart_mem_bridge #(
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [7:0]  AckByte       = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        err_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o
);

  localparam logic [23:0] TmoLast = 24'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StIdle, StTxHdr, StTxAddr, StTxData, StRxData, StRxAck, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [23:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        wr;
  logic        tx_valid, rx_ready;
  logic [7:0]  tx_data;

  assign wr = |wstrb_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = '0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          wstrb_d = mem_wstrb_i;
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          state_d = StTxHdr;
        end
      end
      StTxHdr: begin
        tx_valid = 1'b1;
        tx_data  = {wr, 3'b000, wstrb_q};
        if (tx_tready_i) state_d = StTxAddr;
      end
      StTxAddr: begin
        tx_valid = 1'b1;
        tx_data  = addr_q[{cnt_q, 3'b000} +: 8];
        if (tx_tready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = wr ? StTxData : StRxData;
        end
      end
      StTxData: begin
        tx_valid = 1'b1;
        tx_data  = wdata_q[{cnt_q, 3'b000} +: 8];
        if (tx_tready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StRxAck;
        end
      end
      StRxData: begin
        rx_ready = 1'b1;
        if (rx_tvalid_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rdata_d = {rx_tdata_i, rbuf_q};
            state_d = StDone;
          end else begin
            rbuf_d[{cnt_q, 3'b000} +: 8] = rx_tdata_i;
          end
        end else if (tmo_q == TmoLast) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      StRxAck: begin
        rx_ready = 1'b1;
        if (rx_tvalid_i) begin
          err_d   = (rx_tdata_i != AckByte);
          state_d = StDone;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign tx_tvalid_o = tx_valid & ~reset_i;
  assign tx_tdata_o  = reset_i ? 8'h00 : tx_data;
  assign rx_tready_o = rx_ready & ~reset_i;
  assign mem_ready_o = (state_q == StDone) & ~reset_i;
  assign err_o       = mem_ready_o & err_q;
  // Writes complete with zero read data; the last read value is otherwise held.
  assign mem_rdata_o = (reset_i || (state_q == StDone && wr)) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: expected tx bytes and responses are queued by
// the stimulus and checked by a negedge monitor.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_wstrb_i = '0;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        err_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i = 1'b1;
  logic [7:0]  rx_tdata_i = '0;
  logic        rx_tvalid_i = 1'b0;
  logic        rx_tready_o;

  always #5 clk = ~clk;

  uart_mem_bridge #(.TimeoutCycles(100), .AckByte(8'hA5)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .mem_valid_i(mem_valid_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o),
    .err_o      (err_o),
    .tx_tdata_o (tx_tdata_o),
    .tx_tvalid_o(tx_tvalid_o),
    .tx_tready_i(tx_tready_i),
    .rx_tdata_i (rx_tdata_i),
    .rx_tvalid_i(rx_tvalid_i),
    .rx_tready_o(rx_tready_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  logic [7:0] exp_tx[$];
  resp_t      exp_resp[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_enter = 0;
  int ready_pulses = 0;
  bit rx_rdy_prev = 0;
  bit resp_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected tx bytes and responses as the DUT presents them.
  always @(negedge clk) begin
    if (reset_i) begin
      rx_rdy_prev = 0;
    end else begin
      if (rx_tready_o && !rx_rdy_prev) rx_enter = cyc;
      rx_rdy_prev = rx_tready_o;
      if (tx_tvalid_o) begin
        if (exp_tx.size() == 0) flag("tx_extra");
        else if (tx_tready_i) chk("tx_byte", 32'(tx_tdata_o), 32'(exp_tx.pop_front()));
        else chk("tx_stable", 32'(tx_tdata_o), 32'(exp_tx[0]));
      end
      if (mem_ready_o) begin
        resp_t r;
        ready_pulses++;
        resp_seen = 1;
        if (exp_resp.size() == 0) begin
          flag("resp_extra");
        end else begin
          r = exp_resp.pop_front();
          chk("rdata", mem_rdata_o, r.rdata);
          chk("err", 32'(err_o), 32'(r.err));
          if (r.lat > 0) chk("timeout_lat", 32'(cyc - rx_enter), 32'(r.lat));
        end
      end else if (err_o) begin
        flag("err_without_ready");
      end
    end
  end

  task automatic expect_tx(input int n, input logic [71:0] bytes);
    for (int i = 0; i < n; i++) exp_tx.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
    resp_t r;
    r.rdata = rdata;
    r.err   = err;
    r.lat   = lat;
    exp_resp.push_back(r);
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    mem_addr_i   = addr;
    mem_wdata_i  = wdata;
    mem_wstrb_i  = wstrb;
    mem_valid_i  = 1'b1;
    resp_seen    = 0;
    ready_pulses = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bit ok = 0;
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (rx_tready_o) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_tvalid_i = 1'b0;
    rx_tdata_i  = '0;
    if (!ok) flag("rx_accept_timeout");
  endtask

  task automatic wait_done();
    for (int k = 0; k < 600; k++) begin
      if (resp_seen) break;
      @(posedge clk);
      #1;
    end
    mem_valid_i = 1'b0;
    if (!resp_seen) flag("done_timeout");
    chk("ready_pulses", 32'(ready_pulses), 32'd1);
    chk("tx_left", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(mem_ready_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_tvalid"}, 32'(tx_tvalid_o), 32'd0);
    chk({tag, "_tdata"}, 32'(tx_tdata_o), 32'd0);
    chk({tag, "_rready"}, 32'(rx_tready_o), 32'd0);
    chk({tag, "_rdata"}, mem_rdata_o, 32'd0);
  endtask

  initial begin
    bit bad;
    repeat (2) @(posedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // Read 0x08, data arrives while tx is still running and must wait.
    expect_tx(5, 72'h00_08_00_00_00);
    expect_resp(32'h00110113, 1'b0, 0);
    start_req(32'h8, 32'h0, 4'h0);
    rx_byte(8'h13); rx_byte(8'h01); rx_byte(8'h11); rx_byte(8'h00);
    wait_done();

    // Write with good ack; read data held afterwards.
    expect_tx(9, 72'h8F_FC_03_00_00_05_00_00_00);
    expect_resp(32'h0, 1'b0, 0);
    start_req(32'h3FC, 32'h5, 4'hF);
    rx_byte(8'hA5);
    wait_done();
    chk("rdata_hold", mem_rdata_o, 32'h00110113);

    // Same write with a bad ack.
    expect_tx(9, 72'h8F_FC_03_00_00_05_00_00_00);
    expect_resp(32'h0, 1'b1, 0);
    start_req(32'h3FC, 32'h5, 4'hF);
    rx_byte(8'h00);
    wait_done();

    // Read timeout with no rx bytes.
    expect_tx(5, 72'h00_20_00_00_00);
    expect_resp(32'h0, 1'b1, 100);
    start_req(32'h20, 32'h0, 4'h0);
    wait_done();
    chk("rdata_after_timeout", mem_rdata_o, 32'h0);

    // Header stalled for 50 cycles.
    tx_tready_i = 1'b0;
    expect_tx(5, 72'h00_10_00_00_00);
    expect_resp(32'h44332211, 1'b0, 0);
    start_req(32'h10, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_tvalid_o !== 1'b1 || tx_tdata_o !== 8'h00) bad = 1;
      @(posedge clk);
      #1;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    tx_tready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("next_valid", 32'(tx_tvalid_o), 32'd1);
    chk("next_byte", 32'(tx_tdata_o), 32'h10);
    @(posedge clk);
    #1;
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h44);
    wait_done();

    // Reset in the middle of a read, then a fresh read.
    expect_tx(5, 72'h00_0C_00_00_00);
    expect_resp(32'hBAD0BAD0, 1'b0, 0);
    start_req(32'hC, 32'h0, 4'h0);
    rx_byte(8'hAA);
    rx_byte(8'hBB);
    reset_i = 1'b1;
    mem_valid_i = 1'b0;
    exp_resp.delete();
    chk("tx_left_at_reset", 32'(exp_tx.size()), 32'd0);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    expect_tx(5, 72'h00_04_00_00_00);
    expect_resp(32'hDEADBEEF, 1'b0, 0);
    start_req(32'h4, 32'h0, 4'h0);
    rx_byte(8'hEF); rx_byte(8'hBE); rx_byte(8'hAD); rx_byte(8'hDE);
    wait_done();
    chk("resp_left", 32'(exp_resp.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1000000: max idle cycles between accepted response bytes, range 1..2^24-1.
REQ-002 SHALL have parameter AckByte, default 8'hA5: the expected write-acknowledge byte.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 mem_valid_i  input  1  CPU request valid; held high until mem_ready_o.
REQ-006 mem_addr_i  input  32  request byte address.
REQ-007 mem_wdata_i  input  32  write data.
REQ-008 mem_wstrb_i  input  4  byte strobes; 0 = read, nonzero = write.
REQ-009 mem_ready_o  output  1  one-cycle completion pulse.
REQ-010 mem_rdata_o  output  32  read data; valid when mem_ready_o is high.
REQ-011 err_o  output  1  one-cycle pulse coincident with mem_ready_o on timeout or bad ack.
REQ-012 tx_tdata_o  output  8  byte to UART transmitter (AXI-stream master).
REQ-013 tx_tvalid_o  output  1  tx byte valid.
REQ-014 tx_tready_i  input  1  UART transmitter ready.
REQ-015 rx_tdata_i  input  8  byte from UART receiver (AXI-stream slave).
REQ-016 rx_tvalid_i  input  1  rx byte valid.
REQ-017 rx_tready_o  output  1  bridge accepts rx byte.

Function
REQ-018 States SHALL be IDLE, TX_HDR, TX_ADDR, TX_DATA, RX_DATA, RX_ACK, DONE.
REQ-019 In IDLE with mem_valid_i=1, the bridge SHALL latch addr/wdata/wstrb and enter TX_HDR next cycle.
REQ-020 The header byte SHALL be {wr, 3'b000, wstrb}, with wr = |wstrb.
REQ-021 TX_ADDR SHALL send 4 address bytes, least-significant first; TX_DATA (writes only) SHALL then send 4 wdata bytes, least-significant first.
REQ-022 A tx byte SHALL transfer only on a cycle with tx_tvalid_o&tx_tready_i; tx_tdata_o SHALL stay stable and tx_tvalid_o high until that cycle.
REQ-023 With tx_tready_i held high, consecutive tx bytes SHALL issue on back-to-back cycles.
REQ-024 A 2-bit byte counter SHALL index bytes, advance on each transfer, and wrap 3->0 at each state change.
REQ-025 A read SHALL go TX_ADDR->RX_DATA, and a write SHALL go TX_DATA->RX_ACK.
REQ-026 rx_tready_o SHALL be high only in RX_DATA and RX_ACK; bytes arriving in other states SHALL stay unconsumed.
REQ-027 RX_DATA SHALL assemble 4 bytes little-endian into the rdata register, then enter DONE.
REQ-028 RX_ACK SHALL accept 1 byte, then enter DONE, flagging an error if the byte != AckByte.
REQ-029 In RX states, a timeout counter SHALL increment each cycle without an accepted byte and clear on each accepted byte.
REQ-030 When the timeout counter reaches TimeoutCycles, the bridge SHALL enter DONE with error and rdata = 32'h0.
REQ-031 DONE SHALL last exactly one cycle, asserting mem_ready_o (and err_o if flagged), then return to IDLE.
REQ-032 A new request SHALL be accepted no earlier than the cycle after DONE.
REQ-033 mem_rdata_o SHALL hold its last value until the next read completes; for writes it SHALL be 32'h0.
REQ-034 Read latency with no backpressure SHALL be 5 tx cycles + rx arrival + 1 DONE cycle.

Reset
REQ-035 When reset_i is high at a rising edge, the bridge SHALL enter IDLE regardless of state, including mid-transfer.
REQ-036 During reset, mem_ready_o, err_o, tx_tvalid_o and rx_tready_o SHALL be 0, and tx_tdata_o, mem_rdata_o, counters and latched request SHALL be 0.
REQ-037 In-flight UART bytes SHALL NOT be replayed after reset; recovering the link is the host's responsibility.

Verification
REQ-038 Read addr 0x00000008, rx 13 01 11 00 -> tx 00 08 00 00 00; mem_rdata_o=0x00110113, single mem_ready_o pulse, err_o=0.
REQ-039 Write addr 0x000003FC, wdata 0x00000005, wstrb 0xF, rx A5 -> tx 8F FC 03 00 00 05 00 00 00; mem_ready_o pulse, err_o=0.
REQ-040 Same write with rx 0x00 -> mem_ready_o and err_o pulse together.
REQ-041 TimeoutCycles=100, read, no rx byte -> mem_ready_o+err_o exactly 100 cycles after entering RX_DATA, mem_rdata_o=0.
REQ-042 tx_tready_i low 50 cycles during header -> tx_tvalid_o high and tx_tdata_o=0x00 throughout; the next byte issues one cycle after tready rises.
REQ-043 reset_i asserted after 2 rx bytes of a read -> IDLE; a following read of 0x00000004 returns fresh data correctly.
